// File: rtl/pc_gen.sv
// Program counter generator: sequential fetch advance, trap/jump redirects with
// optional fetch bubble, and rejection of misaligned redirect targets.
module pc_gen #(
  parameter int unsigned        ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  RESET_VEC = '0,
  parameter int unsigned        STEP      = 4,
  parameter int unsigned        HOLD_W    = 3,
  parameter int unsigned        BUBBLE    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump_flag_in,
  input  logic [ADDR_W-1:0] jump_addr_in,
  input  logic              trap_req_in,
  input  logic [ADDR_W-1:0] trap_vec_in,
  input  logic [HOLD_W-1:0] hold_flag_in,
  input  logic              fetch_ready_in,
  output logic [ADDR_W-1:0] pc_out,
  output logic              fetch_valid_out,
  output logic              misalign_out
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_BUBBLE
  } state_t;

  localparam logic [2:0]        BUB_LEN = 3'(BUBBLE);
  localparam logic [ADDR_W-1:0] STEP_V  = ADDR_W'(STEP);

  state_t            state;
  logic [2:0]        cnt;
  logic              redirect;
  logic [ADDR_W-1:0] target;
  logic              transfer;

  always_comb begin
    redirect = trap_req_in | jump_flag_in;
    target   = trap_req_in ? trap_vec_in : jump_addr_in;
    transfer = fetch_valid_out & fetch_ready_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_BOOT;
      pc_out          <= RESET_VEC;
      fetch_valid_out <= 1'b0;
      misalign_out    <= 1'b0;
      cnt             <= '0;
    end else begin
      misalign_out <= 1'b0;
      if (redirect) begin
        // A misaligned target is dropped outright: nothing else moves this cycle.
        if (target[1:0] != 2'b00) begin
          misalign_out <= 1'b1;
        end else begin
          pc_out <= target;
          if (BUB_LEN != 3'd0) begin
            state           <= S_BUBBLE;
            fetch_valid_out <= 1'b0;
            cnt             <= BUB_LEN;
          end else begin
            state           <= S_RUN;
            fetch_valid_out <= 1'b1;
          end
        end
      end else begin
        unique case (state)
          S_BOOT: begin
            state           <= S_RUN;
            pc_out          <= RESET_VEC;
            fetch_valid_out <= 1'b1;
          end
          S_RUN: begin
            if (hold_flag_in == '0 && transfer)
              pc_out <= pc_out + STEP_V;
          end
          S_BUBBLE: begin
            cnt <= cnt - 3'd1;
            if (cnt <= 3'd1) begin
              state           <= S_RUN;
              fetch_valid_out <= 1'b1;
            end
          end
          default: begin
            state           <= S_BOOT;
            fetch_valid_out <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: vector table on a BUBBLE=1 instance plus
// hand-written redirect/reset sequences on a BUBBLE=3 instance.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_flag_in;
  logic [31:0] jump_addr_in;
  logic        trap_req_in;
  logic [31:0] trap_vec_in;
  logic [2:0]  hold_flag_in;
  logic        fetch_ready_in;

  logic [31:0] pc1, pc3;
  logic        v1, v3, m1, m3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_gen u_dut (
    .clk(clk), .rst(rst),
    .jump_flag_in(jump_flag_in), .jump_addr_in(jump_addr_in),
    .trap_req_in(trap_req_in), .trap_vec_in(trap_vec_in),
    .hold_flag_in(hold_flag_in), .fetch_ready_in(fetch_ready_in),
    .pc_out(pc1), .fetch_valid_out(v1), .misalign_out(m1)
  );

  pc_gen #(.BUBBLE(3)) u_b3 (
    .clk(clk), .rst(rst),
    .jump_flag_in(jump_flag_in), .jump_addr_in(jump_addr_in),
    .trap_req_in(trap_req_in), .trap_vec_in(trap_vec_in),
    .hold_flag_in(hold_flag_in), .fetch_ready_in(fetch_ready_in),
    .pc_out(pc3), .fetch_valid_out(v3), .misalign_out(m3)
  );

  typedef struct {
    logic        jump;
    logic [31:0] jaddr;
    logic        trap;
    logic [31:0] tvec;
    logic [2:0]  hold;
    logic        ready;
    logic [31:0] epc;
    logic        ev;
    logic        em;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic j, input logic [31:0] ja, input logic t,
                       input logic [31:0] tv, input logic [2:0] h, input logic r);
    jump_flag_in   = j;
    jump_addr_in   = ja;
    trap_req_in    = t;
    trap_vec_in    = tv;
    hold_flag_in   = h;
    fetch_ready_in = r;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic j, input logic [31:0] ja, input logic t,
                     input logic [31:0] tv, input logic [2:0] h, input logic r,
                     input logic [31:0] epc, input logic ev, input logic em);
    vq.push_back('{j, ja, t, tv, h, r, epc, ev, em});
  endtask

  initial begin
    // sequential fetch from reset
    add(0, 0, 0, 0, 0, 1, 32'h00, 1, 0);
    add(0, 0, 0, 0, 0, 1, 32'h04, 1, 0);
    add(0, 0, 0, 0, 0, 1, 32'h08, 1, 0);
    add(0, 0, 0, 0, 0, 1, 32'h0C, 1, 0);
    add(0, 0, 0, 0, 0, 1, 32'h10, 1, 0);
    // not ready x3, then hold x2, then advance
    add(0, 0, 0, 0, 0, 0, 32'h10, 1, 0);
    add(0, 0, 0, 0, 0, 0, 32'h10, 1, 0);
    add(0, 0, 0, 0, 0, 0, 32'h10, 1, 0);
    add(0, 0, 0, 0, 1, 1, 32'h10, 1, 0);
    add(0, 0, 0, 0, 1, 1, 32'h10, 1, 0);
    add(0, 0, 0, 0, 0, 1, 32'h14, 1, 0);
    add(0, 0, 0, 0, 0, 1, 32'h18, 1, 0);
    add(0, 0, 0, 0, 0, 1, 32'h1C, 1, 0);
    add(0, 0, 0, 0, 0, 1, 32'h20, 1, 0);
    // jump and trap together: trap wins, one bubble
    add(1, 32'h100, 1, 32'h80, 0, 1, 32'h80, 0, 0);
    add(0, 0, 0, 0, 0, 1, 32'h80, 1, 0);
    add(0, 0, 0, 0, 0, 1, 32'h84, 1, 0);
    // misaligned jump rejected
    add(1, 32'h102, 0, 0, 0, 1, 32'h84, 1, 1);
    add(0, 0, 0, 0, 0, 0, 32'h84, 1, 0);
    add(0, 0, 0, 0, 0, 1, 32'h88, 1, 0);
    // misaligned trap wins over aligned jump; whole redirect rejected
    add(1, 32'h200, 1, 32'h81, 0, 1, 32'h88, 1, 1);
    add(0, 0, 0, 0, 0, 0, 32'h88, 1, 0);
    // redirect under hold and no-ready; bubble ends despite hold
    add(1, 32'h300, 0, 0, 3'd5, 0, 32'h300, 0, 0);
    add(0, 0, 0, 0, 3'd5, 1, 32'h300, 1, 0);
    add(0, 0, 0, 0, 3'd5, 1, 32'h300, 1, 0);
    // wrap at the top of the address space
    add(1, 32'hFFFF_FFFC, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    add(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 1, 0);
    add(0, 0, 0, 0, 0, 1, 32'h0000_0000, 1, 0);
    add(0, 0, 0, 0, 0, 1, 32'h0000_0004, 1, 0);

    drive(0, 0, 0, 0, 0, 1);
    rst = 1'b1;
    step();
    step();
    chk("reset_pc", pc1, 32'h0);
    chk("reset_valid", {31'b0, v1}, 32'h0);
    chk("reset_mis", {31'b0, m1}, 32'h0);
    rst = 1'b0;

    foreach (vq[i]) begin
      drive(vq[i].jump, vq[i].jaddr, vq[i].trap, vq[i].tvec, vq[i].hold, vq[i].ready);
      step();
      chk($sformatf("v%0d_pc", i), pc1, vq[i].epc);
      chk($sformatf("v%0d_valid", i), {31'b0, v1}, {31'b0, vq[i].ev});
      chk($sformatf("v%0d_mis", i), {31'b0, m1}, {31'b0, vq[i].em});
    end

    // BUBBLE=3: redirect during bubble restarts the counter
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("b3_boot_exit_valid", {31'b0, v3}, 32'h1);
    chk("b3_boot_exit_pc", pc3, 32'h0);
    drive(1, 32'h40, 0, 0, 0, 0);
    step();
    chk("b3_j1_pc", pc3, 32'h40);
    chk("b3_j1_valid", {31'b0, v3}, 32'h0);
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("b3_bub2_valid", {31'b0, v3}, 32'h0);
    drive(1, 32'h60, 0, 0, 0, 0);
    step();
    chk("b3_j2_pc", pc3, 32'h60);
    drive(0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("b3_bub_c%0d_valid", k), {31'b0, v3}, 32'h0);
      step();
    end
    chk("b3_run_valid", {31'b0, v3}, 32'h1);
    chk("b3_run_pc", pc3, 32'h60);
    step();
    chk("b3_adv_pc", pc3, 32'h64);

    // reset mid-bubble overrides a simultaneous redirect
    drive(1, 32'h40, 0, 0, 0, 1);
    step();
    chk("b3_bub_again_valid", {31'b0, v3}, 32'h0);
    drive(1, 32'h80, 1, 32'h90, 0, 1);
    rst = 1'b1;
    step();
    chk("b3_rst_pc", pc3, 32'h0);
    chk("b3_rst_valid", {31'b0, v3}, 32'h0);
    chk("b3_rst_mis", {31'b0, m3}, 32'h0);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 1);
    step();
    chk("b3_boot_pc", pc3, 32'h0);
    chk("b3_boot_valid", {31'b0, v3}, 32'h1);
    step();
    chk("b3_boot_adv_pc", pc3, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set the PC and target address width.
REQ-002 Parameter RESET_VEC, default 0, SHALL set the PC value loaded on reset.
REQ-003 Parameter STEP, default 4, SHALL set the sequential PC increment in bytes.
REQ-004 Parameter HOLD_W, default 3, SHALL set the hold_flag_in width.
REQ-005 Parameter BUBBLE, default 1, range 0..7, SHALL set the fetch-invalid cycles after a redirect.
REQ-006 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-007 rst  in  1  reset; synchronous, active-high.
REQ-008 jump_flag_in  in  1  branch/jump redirect request.
REQ-009 jump_addr_in  in  ADDR_W  jump target.
REQ-010 trap_req_in  in  1  trap/interrupt redirect request.
REQ-011 trap_vec_in  in  ADDR_W  trap target.
REQ-012 hold_flag_in  in  HOLD_W  pipeline hold level; nonzero freezes sequential advance.
REQ-013 fetch_ready_in  in  1  instruction memory accepts the current fetch.
REQ-014 pc_out  out  ADDR_W  current fetch address (registered).
REQ-015 fetch_valid_out  out  1  pc_out is a valid fetch request (registered).
REQ-016 misalign_out  out  1  one-cycle pulse: rejected misaligned redirect target (registered).

Function
REQ-017 The block SHALL have states BOOT, RUN and BUBBLE.
REQ-018 A fetch transfer SHALL occur in any cycle with fetch_valid_out=1 and fetch_ready_in=1.
REQ-019 In RUN, with no redirect, no hold and a transfer, pc_out SHALL become pc_out+STEP next cycle, modulo 2^ADDR_W (all-ones region wraps to 0).
REQ-020 In RUN, with no redirect and either hold_flag_in!=0 or no transfer, pc_out and fetch_valid_out SHALL remain unchanged.
REQ-021 A redirect SHALL be trap_req_in=1 (target trap_vec_in) or else jump_flag_in=1 (target jump_addr_in); trap SHALL win when both are asserted, and the jump SHALL be discarded.
REQ-022 A redirect SHALL take effect next cycle regardless of hold_flag_in, fetch_ready_in or state (except during rst), abandoning any un-accepted fetch.
REQ-023 On redirect with target[1:0]==0, pc_out SHALL load the target; if BUBBLE>0, the state SHALL become BUBBLE with fetch_valid_out=0 and the bubble counter loaded with BUBBLE; if BUBBLE=0, the state SHALL stay or become RUN with fetch_valid_out=1.
REQ-024 On redirect with target[1:0]!=0, pc_out and the state SHALL be unchanged, misalign_out SHALL be 1 for exactly the next cycle, and no bubble SHALL be inserted.
REQ-025 In BUBBLE, the counter SHALL decrement each cycle, independent of hold; when it reaches 0 (after BUBBLE cycles), the state SHALL become RUN with fetch_valid_out=1.
REQ-026 A valid redirect during BUBBLE SHALL reload pc_out and restart the counter at BUBBLE.
REQ-027 BOOT SHALL last exactly one cycle after rst deasserts, with fetch_valid_out=0, then enter RUN with fetch_valid_out=1 and pc_out=RESET_VEC; a redirect in BOOT SHALL follow REQ-023/024.
REQ-028 misalign_out SHALL be 0 in every cycle not covered by REQ-024.

Reset
REQ-029 While rst=1 at a rising edge: pc_out SHALL be RESET_VEC, fetch_valid_out=0, misalign_out=0, bubble counter=0, and the state SHALL be BOOT.
REQ-030 rst SHALL override all other inputs, including redirects and reset asserted mid-bubble.

Verification
REQ-031 Reset with RESET_VEC=0, ready=1, hold=0 -> valid=0 for 1 cycle after reset, then pc_out = 0, 4, 8, 12 on successive cycles.
REQ-032 RUN at pc=0x10, ready=0 for 3 cycles, then hold=1 for 2 cycles with ready=1 -> pc_out stays 0x10 and valid stays 1 for all 5 cycles, then advances to 0x14.
REQ-033 At pc=0x20, assert jump=1 to 0x100 and trap=1 to 0x80 in the same cycle with BUBBLE=1 -> next cycle pc_out=0x80 with valid=0, then valid=1 at 0x80, then 0x84.
REQ-034 Jump to 0x102 -> pc_out unchanged, misalign_out=1 for exactly 1 cycle, and valid unaffected.
REQ-035 ADDR_W=32 at pc=0xFFFFFFFC with a transfer -> pc_out=0x00000000 next cycle.
REQ-036 BUBBLE=3, jump to 0x40, second jump to 0x60 on the 2nd bubble cycle -> pc_out=0x60 and valid=0 for 3 further cycles; assert rst in the next run -> pc_out=RESET_VEC and BOOT.
